// File: rtl/ahb_arbiter.sv
// ahb_arbiter
// Central AHB bus arbiter. It samples every master's bus and lock requests
// and grants the bus to exactly one master. Ownership moves only at
// arbitration points, and locked sequences are honoured. hmaster steers the
// address/control mux.
//
// Handshake: a master holds hbusreq until it sees its hgrant bit.
// hready=1 marks a completed transfer. An edge with hready=0 changes no state.
// The grant moves only on an edge where all of these hold:
//   - hready=1,
//   - htrans is IDLE or NONSEQ,
//   - the arbiter is not inside a locked sequence or its tail.
//
// Ports:
//   hclk, hreset     clock, synchronous active-high reset
//   hbusreq, hlock   per-master bus request and locked-access request
//   hready           transfer-done from the slave response mux
//   htrans           transfer type of the current address phase
//   hgrant           registered one-hot grant
//   hmaster          registered index of the address-phase owner (4 bits)
//   hmastlock        combinational |(hgrant & hlock)
//   dbg_state        FSM state (DEFAULT=0, OWNED=1, LOCKED=2, LOCK_TAIL=3)
//   dbg_rr_ptr       round-robin search start, zero-extended to 4 bits
module ahb_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DEFAULT_MASTER = NUM_MASTERS - 1,
    parameter int ARB_MODE       = 0
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic                   hready,
    input  logic [1:0]             htrans,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [3:0]             hmaster,
    output logic                   hmastlock,
    output logic [1:0]             dbg_state,
    output logic [3:0]             dbg_rr_ptr
);

    localparam int PW = $clog2(NUM_MASTERS);
    localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
    localparam logic [1:0] HTRANS_BUSY = 2'b01;
    localparam logic [1:0] HTRANS_SEQ  = 2'b11;

    typedef enum logic [1:0] {
        ST_DEFAULT   = 2'd0,
        ST_OWNED     = 2'd1,
        ST_LOCKED    = 2'd2,
        ST_LOCK_TAIL = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [NUM_MASTERS-1:0]   grant_q, grant_d;
    logic [3:0]               hmaster_q, hmaster_d;
    logic [PW-1:0]            rr_ptr_q, rr_ptr_d;

    logic [3:0]               owner_idx;
    logic                     owner_lock;
    logic                     owner_req;
    logic                     any_req;
    logic                     ap;
    logic                     arb_en;
    logic [PW-1:0]            winner_idx;
    logic [NUM_MASTERS-1:0]   winner_grant;
    logic [PW-1:0]            rr_next;
    int                       idx;

    assign hgrant     = grant_q;
    assign hmaster    = hmaster_q;
    assign hmastlock  = |(grant_q & hlock);
    assign dbg_state  = state_q;
    assign dbg_rr_ptr = 4'(rr_ptr_q);

    assign owner_lock = |(grant_q & hlock);
    assign owner_req  = |(grant_q & hbusreq);
    assign any_req    = |hbusreq;

    // A transfer inside a burst (SEQ/BUSY) must not lose its bus. A locked
    // sequence and its tail also keep the current owner.
    assign ap = hready && (htrans != HTRANS_BUSY) && (htrans != HTRANS_SEQ) &&
                ((state_q == ST_DEFAULT) || (state_q == ST_OWNED));

    // Encode the current one-hot grant.
    always_comb begin
        owner_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                owner_idx = 4'(i);
            end
        end
    end

    // Winner selection. Fixed priority takes the lowest requesting index.
    // Round-robin searches upward from rr_ptr_q and wraps.
    always_comb begin
        winner_idx = '0;
        idx        = 0;
        if (ARB_MODE == 0) begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                if (hbusreq[i]) begin
                    winner_idx = PW'(i);
                end
            end
        end else begin
            for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
                idx = int'(rr_ptr_q) + i;
                if (idx >= NUM_MASTERS) begin
                    idx = idx - NUM_MASTERS;
                end
                if (hbusreq[idx]) begin
                    winner_idx = PW'(idx);
                end
            end
        end
    end

    assign winner_grant = NUM_MASTERS'(1) << winner_idx;
    assign rr_next      = (int'(winner_idx) == NUM_MASTERS - 1) ? '0 : winner_idx + PW'(1);

    // Next-state, grant, hmaster and round-robin pointer.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        hmaster_d = hmaster_q;
        rr_ptr_d  = rr_ptr_q;
        arb_en    = 1'b0;

        // hmaster trails the grant by one completed transfer.
        if (hready) begin
            hmaster_d = owner_idx;
        end

        case (state_q)
            ST_DEFAULT: begin
                if (ap && any_req) begin
                    arb_en = 1'b1;
                end
            end
            ST_OWNED: begin
                // A lock from the owner takes precedence over re-arbitration
                // on the same edge.
                if (hready && owner_lock && owner_req) begin
                    state_d = ST_LOCKED;
                end else if (ap) begin
                    if (any_req) begin
                        arb_en = 1'b1;
                    end else begin
                        state_d = ST_DEFAULT;
                        grant_d = DEFAULT_GRANT;
                    end
                end
            end
            ST_LOCKED: begin
                if (hready && !owner_lock) begin
                    state_d = ST_LOCK_TAIL;
                end
            end
            ST_LOCK_TAIL: begin
                // The final locked transfer completes on this edge. The
                // owner keeps the bus until the next arbitration point.
                if (hready) begin
                    state_d = ST_OWNED;
                end
            end
            default: begin
                state_d = ST_DEFAULT;
                grant_d = DEFAULT_GRANT;
            end
        endcase

        if (arb_en) begin
            grant_d  = winner_grant;
            rr_ptr_d = rr_next;
            state_d  = hlock[winner_idx] ? ST_LOCKED : ST_OWNED;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q   <= ST_DEFAULT;
            grant_q   <= DEFAULT_GRANT;
            hmaster_q <= 4'(DEFAULT_MASTER);
            rr_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            hmaster_q <= hmaster_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: one fixed-priority and one round-robin instance
// share the same inputs. Each step drives the inputs and queues the
// expected post-edge outputs per instance. A monitor per instance pops one
// entry per clock edge and compares.
module tb_ahb_arbiter;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;
    localparam int W = 21;

    logic       hclk = 1'b0;
    logic       hreset;
    logic [3:0] hbusreq;
    logic [3:0] hlock;
    logic       hready;
    logic [1:0] htrans;

    logic [3:0] g0, g1, m0, m1, rr0_w, rr1_w;
    logic       ml0, ml1;
    logic [1:0] st0, st1;

    int checks = 0;
    int errors = 0;
    logic [7:0] step_id = '0;

    // Entry layout: [20:13] step, [12] check, [11] check rr,
    // [10:7] grant, [6:3] master, [2] mastlock, [1:0] rr_ptr
    logic [W-1:0] exp0_q[$];
    logic [W-1:0] exp1_q[$];

    always #5 hclk = ~hclk;

    ahb_arbiter #(.NUM_MASTERS(4), .ARB_MODE(0)) u_fixed (
        .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
        .hready(hready), .htrans(htrans), .hgrant(g0), .hmaster(m0),
        .hmastlock(ml0), .dbg_state(st0), .dbg_rr_ptr(rr0_w)
    );

    ahb_arbiter #(.NUM_MASTERS(4), .ARB_MODE(1)) u_rr (
        .hclk(hclk), .hreset(hreset), .hbusreq(hbusreq), .hlock(hlock),
        .hready(hready), .htrans(htrans), .hgrant(g1), .hmaster(m1),
        .hmastlock(ml1), .dbg_state(st1), .dbg_rr_ptr(rr1_w)
    );

    task automatic cmp(input int dut, input logic [7:0] sid, input string what,
                       input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL step %0d dut%0d %s: got %b want %b", sid, dut, what, act, exp);
        end
    endtask

    task automatic check_entry(input int dut, input logic [W-1:0] e,
                               input logic [3:0] g, input logic [3:0] m,
                               input logic ml, input logic [3:0] rr);
        if (e[12]) begin
            cmp(dut, e[20:13], "hgrant", g, e[10:7]);
            cmp(dut, e[20:13], "hmaster", m, e[6:3]);
            cmp(dut, e[20:13], "hmastlock", {3'b0, ml}, {3'b0, e[2]});
            if (e[11]) begin
                cmp(dut, e[20:13], "rr_ptr", rr, {2'b0, e[1:0]});
            end
        end
    endtask

    // Monitors: one expectation is consumed per clock edge.
    always begin
        logic [W-1:0] e;
        @(posedge hclk);
        #1;
        if (exp0_q.size() > 0) begin
            e = exp0_q.pop_front();
            check_entry(0, e, g0, m0, ml0, rr0_w);
        end
    end

    always begin
        logic [W-1:0] e;
        @(posedge hclk);
        #1;
        if (exp1_q.size() > 0) begin
            e = exp1_q.pop_front();
            check_entry(1, e, g1, m1, ml1, rr1_w);
        end
    end

    // Drive one cycle of inputs and queue what each instance must show after
    // the edge. mask selects which instance is checked.
    task automatic step(input logic r, input logic [3:0] req, input logic [3:0] lk,
                        input logic rdy, input logic [1:0] tr, input logic [1:0] mask,
                        input logic [3:0] g, input logic [3:0] m, input logic ml,
                        input logic crr, input logic [1:0] rr);
        hreset  = r;
        hbusreq = req;
        hlock   = lk;
        hready  = rdy;
        htrans  = tr;
        step_id = step_id + 8'd1;
        exp0_q.push_back({step_id, mask[0], crr, g, m, ml, rr});
        exp1_q.push_back({step_id, mask[1], crr, g, m, ml, rr});
        @(posedge hclk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        hreset = 1'b1; hbusreq = '0; hlock = '0; hready = 1'b1; htrans = T_IDLE;

        // Reset default, both instances
        step(1, 4'b0000, 4'b0000, 1, T_IDLE, 2'b11, 4'b1000, 4'd3, 0, 1, 2'd0);
        step(1, 4'b0000, 4'b0000, 1, T_IDLE, 2'b11, 4'b1000, 4'd3, 0, 1, 2'd0);
        step(0, 4'b0000, 4'b0000, 1, T_IDLE, 2'b11, 4'b1000, 4'd3, 0, 1, 2'd0);

        // Fixed-priority handover
        step(0, 4'b0110, 4'b0000, 1, T_NONSEQ, 2'b01, 4'b0010, 4'd3, 0, 0, 2'd0);
        step(0, 4'b0110, 4'b0000, 1, T_NONSEQ, 2'b01, 4'b0010, 4'd1, 0, 0, 2'd0);
        step(0, 4'b0100, 4'b0000, 1, T_NONSEQ, 2'b01, 4'b0100, 4'd1, 0, 0, 2'd0);
        step(0, 4'b0100, 4'b0000, 1, T_NONSEQ, 2'b01, 4'b0100, 4'd2, 0, 0, 2'd0);

        // Burst protection: master 0 waits through SEQ beats
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b0101, 4'b0000, 1, T_SEQ, 2'b01, 4'b0100, 4'd2, 0, 0, 2'd0);
        end
        step(0, 4'b0101, 4'b0000, 1, T_NONSEQ, 2'b01, 4'b0001, 4'd2, 0, 0, 2'd0);
        step(0, 4'b0010, 4'b0000, 1, T_NONSEQ, 2'b01, 4'b0010, 4'd0, 0, 0, 2'd0);

        // Locked sequence: master 1 locks while master 0 requests
        for (int i = 0; i < 5; i++) begin
            step(0, 4'b0011, 4'b0010, 1, T_NONSEQ, 2'b01, 4'b0010, 4'd1, 1, 0, 2'd0);
        end
        step(0, 4'b0011, 4'b0000, 1, T_NONSEQ, 2'b01, 4'b0010, 4'd1, 0, 0, 2'd0);
        step(0, 4'b0011, 4'b0000, 1, T_NONSEQ, 2'b01, 4'b0010, 4'd1, 0, 0, 2'd0);
        step(0, 4'b0011, 4'b0000, 1, T_NONSEQ, 2'b01, 4'b0001, 4'd1, 0, 0, 2'd0);

        // hready stall with a pending change to master 2
        for (int i = 0; i < 4; i++) begin
            step(0, 4'b0100, 4'b0000, 0, T_NONSEQ, 2'b01, 4'b0001, 4'd1, 0, 0, 2'd0);
        end
        step(0, 4'b0100, 4'b0000, 1, T_NONSEQ, 2'b01, 4'b0100, 4'd0, 0, 0, 2'd0);

        // Fresh reset for round-robin
        step(1, 4'b0000, 4'b0000, 1, T_IDLE, 2'b11, 4'b1000, 4'd3, 0, 1, 2'd0);
        step(1, 4'b0000, 4'b0000, 1, T_IDLE, 2'b11, 4'b1000, 4'd3, 0, 1, 2'd0);
        step(0, 4'b0000, 4'b0000, 1, T_IDLE, 2'b11, 4'b1000, 4'd3, 0, 1, 2'd0);

        // Round-robin rotation 0,1,2,3,0
        step(0, 4'b1111, 4'b0000, 1, T_NONSEQ, 2'b10, 4'b0001, 4'd3, 0, 1, 2'd1);
        step(0, 4'b1111, 4'b0000, 1, T_NONSEQ, 2'b10, 4'b0010, 4'd0, 0, 1, 2'd2);
        step(0, 4'b1111, 4'b0000, 1, T_NONSEQ, 2'b10, 4'b0100, 4'd1, 0, 1, 2'd3);
        step(0, 4'b1111, 4'b0000, 1, T_NONSEQ, 2'b10, 4'b1000, 4'd2, 0, 1, 2'd0);
        step(0, 4'b1111, 4'b0000, 1, T_NONSEQ, 2'b10, 4'b0001, 4'd3, 0, 1, 2'd1);

        // Round-robin stall: grant, hmaster and rr_ptr hold
        for (int i = 0; i < 4; i++) begin
            step(0, 4'b1111, 4'b0000, 0, T_NONSEQ, 2'b10, 4'b0001, 4'd3, 0, 1, 2'd1);
        end
        step(0, 4'b1111, 4'b0000, 1, T_NONSEQ, 2'b10, 4'b0010, 4'd0, 0, 1, 2'd2);

        // No requester: default master, rr_ptr unchanged; then wrap 3 -> 0
        step(0, 4'b0000, 4'b0000, 1, T_NONSEQ, 2'b10, 4'b1000, 4'd1, 0, 1, 2'd2);
        step(0, 4'b1001, 4'b0000, 1, T_NONSEQ, 2'b10, 4'b1000, 4'd3, 0, 1, 2'd0);
        step(0, 4'b0000, 4'b0000, 1, T_IDLE,   2'b10, 4'b1000, 4'd3, 0, 1, 2'd0);

        repeat (3) @(posedge hclk);
        #2;
        checks++;
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d/%0d entries left want 0/0", exp0_q.size(), exp1_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
